// File: rtl/tx_frame_mapper_if.sv
// Stream bundle for tx_frame_mapper: 2-bit symbol input, packed I/Q sample output.
// The slave modport is the mapper's view; master is the surrounding chain's view.
interface tx_frame_mapper_if #(
  parameter int IQ_W = 12
);
  logic              in_valid;
  logic [1:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [2*IQ_W-1:0] out_data;
  logic              out_ready;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tx_frame_mapper.sv
// TX framing and symbol mapper: prepends a QPSK header to each payload frame,
// maps symbols to signed I/Q (QPSK or BPSK) and zero-stuffs each to OSR samples.
module tx_frame_mapper #(
  parameter int                   IQ_W        = 12,
  parameter int                   AMP         = 1024,
  parameter int                   HDR_LEN     = 16,
  parameter logic [2*HDR_LEN-1:0] HDR_PATTERN = 32'hF0F0_3C3C,
  parameter int                   FRAME_LEN   = 256,
  parameter int                   OSR         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  output logic                  busy,
  tx_frame_mapper_if.slave      io
);

  localparam int SYM_MAX = (HDR_LEN > FRAME_LEN) ? HDR_LEN : FRAME_LEN;
  localparam int SYM_W   = (SYM_MAX > 1) ? $clog2(SYM_MAX) : 1;
  localparam int PH_W    = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [SYM_W-1:0] HDR_LAST = SYM_W'(HDR_LEN - 1);
  localparam logic [SYM_W-1:0] PAY_LAST = SYM_W'(FRAME_LEN - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
  localparam logic [IQ_W-1:0]  POS      = IQ_W'(AMP);
  localparam logic [IQ_W-1:0]  NEG      = IQ_W'(-AMP);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               mode_r;
  logic [PH_W-1:0]    phase;
  logic [PH_W-1:0]    phase_nxt;
  logic [SYM_W-1:0]   sym;
  logic [SYM_W-1:0]   sym_nxt;

  logic               out_valid_r;
  logic               out_last_r;
  logic [2*IQ_W-1:0]  out_data_r;

  logic               load_en;
  logic               have_sample;
  logic               adv;
  logic               start;
  logic               phase_end;
  logic               sym_end;
  logic               last_nxt;

  logic [2*HDR_LEN-1:0] hdr_shift;
  logic [1:0]           hdr_bits;
  logic [1:0]           sym_bits;
  logic [IQ_W-1:0]      i_val;
  logic [IQ_W-1:0]      q_val;
  logic [2*IQ_W-1:0]    sample;

  // Output register accepts a new sample whenever it is empty or being drained.
  assign load_en   = ~out_valid_r | io.out_ready;
  assign phase_end = (phase == PH_LAST);
  assign adv       = load_en & have_sample;

  assign io.in_ready  = (state == PAY) & (phase == '0) & load_en;
  assign io.out_valid = out_valid_r;
  assign io.out_data  = out_data_r;
  assign io.out_last  = out_last_r;
  assign busy         = (state != IDLE);

  // Header symbol k lives MSB-first in the pattern; beyond HDR_LEN the shift
  // simply runs off the end, which is harmless since it is only used in HDR.
  always_comb begin
    hdr_shift = HDR_PATTERN >> (2 * (HDR_LEN - 1 - int'(sym)));
    hdr_bits  = hdr_shift[1:0];
  end

  always_comb begin
    sym_bits = (state == HDR) ? hdr_bits : io.in_data;
    i_val    = sym_bits[1] ? POS : NEG;
    if ((state == PAY) && mode_r) begin
      q_val = '0;
    end else begin
      q_val = sym_bits[0] ? POS : NEG;
    end
    sample = (phase == '0) ? {i_val, q_val} : '0;
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    sym_nxt     = sym;
    have_sample = 1'b0;
    start       = 1'b0;
    sym_end     = 1'b0;
    last_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (io.in_valid) begin
          start     = 1'b1;
          state_nxt = HDR;
          phase_nxt = '0;
          sym_nxt   = '0;
        end
      end
      HDR: begin
        have_sample = 1'b1;
        sym_end     = (sym == HDR_LAST);
      end
      PAY: begin
        // Only phase 0 needs a fresh input symbol; stuffing phases always exist.
        have_sample = (phase != '0) | io.in_valid;
        sym_end     = (sym == PAY_LAST);
        last_nxt    = sym_end & phase_end;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (adv) begin
      if (phase_end) begin
        phase_nxt = '0;
        if (sym_end) begin
          sym_nxt   = '0;
          state_nxt = (state == HDR) ? PAY : IDLE;
        end else begin
          sym_nxt = sym + 1'b1;
        end
      end else begin
        phase_nxt = phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= '0;
      sym    <= '0;
      mode_r <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      sym   <= sym_nxt;
      if (start) begin
        mode_r <= mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else if (adv) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sample;
      out_last_r  <= last_nxt;
    end else if (load_en) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

endmodule
